// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        RUN,
        FIX,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_t;

    localparam int unsigned STEPS            = 32;
    localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

    function automatic logic signed_a(input op_t o);
        return (o == OP_MULH) || (o == OP_MULHSU) || (o == OP_DIV) || (o == OP_REM);
    endfunction

    function automatic logic signed_b(input op_t o);
        return (o == OP_MULH) || (o == OP_DIV) || (o == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_seq_arith.sv
// Ripple add/subtract unit: sum = x + y (afn=0) or x - y (afn=1), with carry-out.
module muldiv_seq_arith #(
    parameter int W = 32
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         afn,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W:0] total;

    always_comb begin
        total = {1'b0, x} + {1'b0, (afn ? ~y : y)} + {{W{1'b0}}, afn};
    end

    assign sum  = total[W-1:0];
    assign cout = total[W];

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide: 32-step shift-add multiply / restoring divide
// over one shared add/subtract unit, fixed 35-cycle latency.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    state_t          state, state_n;
    op_t             op_r;
    logic [XLEN-1:0] a_r, dv, hi, lo, hs;
    logic [4:0]      cnt;
    logic            sa, sb, bz, ovf, ge;
    logic [XLEN-1:0] ax, ay, sum, res_n;
    logic            afn, cout;

    muldiv_seq_arith #(.W(XLEN)) u_arith (
        .x    (ax),
        .y    (ay),
        .afn  (afn),
        .sum  (sum),
        .cout (cout)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = PREP;
            PREP:    state_n = RUN;
            RUN:     if (cnt == 5'(STEPS - 1)) state_n = FIX;
            FIX:     state_n = DONE;
            DONE:    state_n = start ? PREP : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    assign busy = (state == PREP) || (state == RUN) || (state == FIX);
    assign done = (state == DONE);

    // The adder is idle while waiting for start, so the divisor/multiplicand
    // magnitude is taken there; PREP then only has to negate a.
    always_comb begin
        hs  = {hi[XLEN-2:0], lo[XLEN-1]};
        ge  = hi[XLEN-1] | cout;
        ax  = '0;
        ay  = '0;
        afn = 1'b0;
        case (state)
            IDLE, DONE: begin ay = b;    afn = 1'b1; end
            PREP:       begin ay = a_r;  afn = 1'b1; end
            RUN: begin
                ax  = op_r[2] ? hs : hi;
                ay  = dv;
                afn = op_r[2];
            end
            FIX: begin
                case (op_r)
                    // high word of a 64-bit negation: ~hi + borrow-free low word
                    OP_MULH, OP_MULHSU, OP_MULHU: begin
                        ax = ~hi; ay = XLEN'(lo == '0); afn = 1'b0;
                    end
                    OP_REM, OP_REMU: begin ay = hi; afn = 1'b1; end
                    default:         begin ay = lo; afn = 1'b1; end
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        res_n = lo;
        case (op_r)
            OP_MUL:                       res_n = (sa ^ sb) ? sum : lo;
            OP_MULH, OP_MULHSU, OP_MULHU: res_n = (sa ^ sb) ? sum : hi;
            OP_DIV, OP_DIVU: begin
                if (bz)                         res_n = '1;
                else if (ovf && op_r == OP_DIV) res_n = DIV_OVF_DIVIDEND;
                else                            res_n = (sa ^ sb) ? sum : lo;
            end
            default: begin
                if (bz)                         res_n = a_r;
                else if (ovf && op_r == OP_REM) res_n = '0;
                else                            res_n = sa ? sum : hi;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_r   <= OP_MUL;
            a_r    <= '0;
            dv     <= '0;
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            bz     <= 1'b0;
            ovf    <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op_r <= op_t'(op);
                        a_r  <= a;
                        sa   <= a[XLEN-1] & signed_a(op_t'(op));
                        sb   <= b[XLEN-1] & signed_b(op_t'(op));
                        dv   <= (b[XLEN-1] & signed_b(op_t'(op))) ? sum : b;
                        bz   <= (b == '0);
                        ovf  <= (a == DIV_OVF_DIVIDEND) && (b == '1);
                    end
                end
                PREP: begin
                    lo  <= sa ? sum : a_r;
                    hi  <= '0;
                    cnt <= '0;
                end
                RUN: begin
                    cnt <= cnt + 5'd1;
                    if (op_r[2]) begin
                        hi <= ge ? sum : hs;
                        lo <= {lo[XLEN-2:0], ge};
                    end else if (lo[0]) begin
                        hi <= {cout, sum[XLEN-1:1]};
                        lo <= {sum[0], lo[XLEN-1:1]};
                    end else begin
                        hi <= {1'b0, hi[XLEN-1:1]};
                        lo <= {hi[0], lo[XLEN-1:1]};
                    end
                end
                FIX: result <= res_n;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: vector table plus multi-cycle corner sequences.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] sb_q[$];
    int          tag_q[$];

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    muldiv_seq #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: result %h with no op outstanding", result);
            end else begin
                check($sformatf("result_t%0d", tag_q.pop_front()), result, sb_q.pop_front());
            end
        end
    end

    function automatic void add(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                input logic [31:0] e);
        vecs.push_back({o, x, y, e});
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] e, input int tag, input bit expect_done);
        op = o; a = x; b = y; start = 1'b1;
        if (expect_done) begin
            sb_q.push_back(e);
            tag_q.push_back(tag);
        end
    endtask

    task automatic wait_done(input int inject_at, output int cyc, output int busy_cyc);
        cyc = 0;
        busy_cyc = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (busy) busy_cyc++;
            if (done) break;
            if (cyc == inject_at) begin
                start = 1'b1; op = 3'd5; a = 32'd1000; b = 32'd10;
            end
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] e, input int tag, input int inject_at);
        int c, bc;
        issue(o, x, y, e, tag, 1'b1);
        wait_done(inject_at, c, bc);
        check($sformatf("latency_t%0d", tag), 32'(c), 32'd35);
        check($sformatf("busy_cycles_t%0d", tag), 32'(bc), 32'd34);
    endtask

    initial begin
        int c, bc;
        add(OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB);
        add(OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000);
        add(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        add(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        add(OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
        add(OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
        add(OP_DIVU,   32'd100,      32'd7,        32'd14);
        add(OP_REMU,   32'd100,      32'd7,        32'd2);
        add(OP_DIV,    32'd5,        32'd0,        32'hFFFFFFFF);
        add(OP_REM,    32'd5,        32'd0,        32'd5);
        add(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        add(OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0);
        add(OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF);
        add(OP_REMU,   32'd5,        32'd0,        32'd5);
        add(OP_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'd0);
        add(OP_REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        add(OP_MULH,   32'h80000000, 32'd2,        32'hFFFFFFFF);
        add(OP_MUL,    32'h80000000, 32'd2,        32'd0);
        add(OP_MULH,   32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        add(OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD);
        add(OP_REM,    32'd7,        32'hFFFFFFFE, 32'd1);
        add(OP_REM,    32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF);
        add(OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1);
        add(OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0);
        add(OP_MULHU,  32'h00010000, 32'h00010000, 32'd1);

        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, i, 0);
            @(negedge clk);
        end

        // start pulse in the middle of RUN must be ignored
        run_op(OP_MUL, 32'd7, 32'd3, 32'd21, 100, 10);
        @(negedge clk);
        check("idle_after_ignored_start", {31'd0, busy}, 32'd0);

        // reset on RUN step 10 aborts the op with no done pulse
        issue(OP_DIV, 32'd100, 32'd7, 32'd0, 101, 1'b0);
        repeat (12) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("busy_before_abort", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_result", result, 32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_still_idle", {31'd0, busy}, 32'd0);

        // rst and start together: start dropped
        rst = 1'b1; start = 1'b1; op = 3'd0; a = 32'd1; b = 32'd1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_start_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);

        run_op(OP_DIVU, 32'd9, 32'd3, 32'd3, 102, 0);
        @(negedge clk);

        // back-to-back: second start issued in the DONE cycle
        issue(OP_REMU, 32'd100, 32'd7, 32'd2, 103, 1'b1);
        wait_done(0, c, bc);
        check("b2b_first_latency", 32'(c), 32'd35);
        issue(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 104, 1'b1);
        wait_done(0, c, bc);
        check("b2b_second_latency", 32'(c), 32'd35);
        check("b2b_second_busy", 32'(bc), 32'd34);
        @(negedge clk);
        check("b2b_done_pulse_len", {31'd0, done}, 32'd0);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete, %0d checks so far", n_checks);
        $fatal(1, "timeout");
    end

endmodule
